pulse_sync_sched: RTL and testbench



---
 rtl/pulse_sync_sched_if.sv | 25 ++
 rtl/pulse_sync_sched.sv | 127 ++++++++++++
 tb/tb_pulse_sync_sched.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_sync_sched_if.sv
// Signal bundle between the pulse scheduler and its requester / synchronizer side.
interface pulse_sync_sched_if #(
    parameter int N_REQ = 4
);
    localparam int ID_W = $clog2(N_REQ);

    logic             enable;
    logic [N_REQ-1:0] req_pulse;
    logic             clr_ovf;
    logic             sync_pulse;
    logic [ID_W-1:0]  sync_id;
    logic             busy;
    logic [N_REQ-1:0] ovf;
    logic             pend_any;

    modport master (
        output enable, req_pulse, clr_ovf,
        input  sync_pulse, sync_id, busy, ovf, pend_any
    );

    modport slave (
        input  enable, req_pulse, clr_ovf,
        output sync_pulse, sync_id, busy, ovf, pend_any
    );
endinterface

// File: rtl/pulse_sync_sched.sv
// Round-robin scheduler sharing one fast-to-slow pulse synchronizer among N_REQ requesters,
// with saturating per-requester pending counts and GAP-cycle launch spacing.
module pulse_sync_sched #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 4,
    parameter int GAP   = 8
) (
    input  logic              clk_fast,
    input  logic              rst,
    pulse_sync_sched_if.slave bus
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int GAP_W = $clog2(GAP + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP - 1);
    localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_HOLD} state_t;

    state_t                      r_state;
    state_t                      w_state_nx;
    logic [N_REQ-1:0][CNT_W-1:0] r_cnt;
    logic [N_REQ-1:0]            r_ovf;
    logic [N_REQ-1:0]            w_pend;
    logic [N_REQ-1:0]            w_dec;
    logic [N_REQ-1:0]            w_ovf_set;
    logic [ID_W-1:0]             r_id;
    logic [ID_W-1:0]             r_last;
    logic [ID_W-1:0]             w_grant;
    logic [ID_W-1:0]             w_idx;
    logic [GAP_W-1:0]            r_gap;
    logic                        r_pulse;
    logic                        r_busy;
    logic                        w_load;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_pend[i]    = (r_cnt[i] != '0);
            w_dec[i]     = (r_state == S_LAUNCH) && (r_id == ID_W'(i));
            w_ovf_set[i] = bus.req_pulse[i] && !w_dec[i] && (r_cnt[i] == CNT_MAX);
        end
    end

    // Descending scan so the nearest pending requester after r_last wins.
    always_comb begin
        w_grant = r_last;
        w_idx   = r_last;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = ID_W'((int'(r_last) + k) % N_REQ);
            if (w_pend[w_idx]) begin
                w_grant = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.enable && (|w_pend)) begin
                    w_state_nx = S_LAUNCH;
                    w_load     = 1'b1;
                end
            end
            S_LAUNCH: w_state_nx = S_HOLD;
            S_HOLD: begin
                if (r_gap == '0) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Pulse and busy come straight from flops so the synchronizer input is glitch-free.
    always_ff @(posedge clk_fast) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_id    <= '0;
            r_last  <= LAST_INIT;
            r_gap   <= '0;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_pulse <= (w_state_nx == S_LAUNCH);
            r_busy  <= (w_state_nx != S_IDLE);
            if (w_load) begin
                r_id   <= w_grant;
                r_last <= w_grant;
            end
            if (r_state == S_LAUNCH) begin
                r_gap <= GAP_LOAD;
            end else if ((r_state == S_HOLD) && (r_gap != '0)) begin
                r_gap <= r_gap - GAP_W'(1);
            end
        end
    end

    always_ff @(posedge clk_fast) begin
        if (rst) begin
            r_cnt <= '0;
            r_ovf <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                case ({bus.req_pulse[i], w_dec[i]})
                    2'b10: begin
                        if (r_cnt[i] != CNT_MAX) begin
                            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                        end
                    end
                    2'b01:   r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                    default: ;
                endcase
            end
            // A new loss in the same cycle as a clear must stay visible.
            r_ovf <= (bus.clr_ovf ? '0 : r_ovf) | w_ovf_set;
        end
    end

    assign bus.sync_pulse = r_pulse;
    assign bus.sync_id    = r_id;
    assign bus.busy       = r_busy;
    assign bus.ovf        = r_ovf;
    assign bus.pend_any   = |w_pend;
endmodule

// File: tb/tb_pulse_sync_sched.sv
// Directed bench for pulse_sync_sched: latency, rotation, saturation, collision, enable and reset cases.
module tb_pulse_sync_sched;
    localparam int N_REQ = 4;
    localparam int CNT_W = 4;
    localparam int GAP   = 8;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;
    int   q_t[$];
    int   q_id[$];
    int   t0;
    int   t1;
    int   nbusy;
    int   nother;

    pulse_sync_sched_if #(.N_REQ(N_REQ)) bus ();

    pulse_sync_sched #(
        .N_REQ(N_REQ),
        .CNT_W(CNT_W),
        .GAP  (GAP)
    ) dut (
        .clk_fast(clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.sync_pulse === 1'b1) begin
            q_t.push_back(cyc);
            q_id.push_back(int'(bus.sync_id));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.req_pulse = '0;
        bus.clr_ovf = 1'b0;
        tick_n(2);
        rst = 1'b0;
        q_t.delete();
        q_id.delete();
    endtask

    initial begin
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.req_pulse = '0;
        bus.clr_ovf = 1'b0;

        // Reset values
        do_reset();
        chk("rst_pulse", 32'(bus.sync_pulse), 0);
        chk("rst_id", 32'(bus.sync_id), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ovf", 32'(bus.ovf), 0);
        chk("rst_pend", 32'(bus.pend_any), 0);
        chk("rst_cnt", 32'(dut.r_cnt), 0);

        // Single request: pulse 2 cycles later, busy for GAP+1 cycles
        bus.enable = 1'b1;
        tick_n(3);
        q_t.delete();
        q_id.delete();
        t0 = cyc;
        bus.req_pulse = 4'b0100;
        tick();
        bus.req_pulse = '0;
        chk("t1_pend", 32'(bus.pend_any), 1);
        chk("t1_cnt2_inc", 32'(dut.r_cnt[2]), 1);
        chk("t1_early", 32'(bus.sync_pulse), 0);
        tick();
        chk("t1_pulse", 32'(bus.sync_pulse), 1);
        chk("t1_id", 32'(bus.sync_id), 2);
        nbusy = 0;
        for (int i = 0; i < 28; i++) begin
            if (bus.busy === 1'b1) nbusy++;
            tick();
        end
        chk("t1_busy_len", nbusy, 9);
        chk("t1_npulse", q_t.size(), 1);
        if (q_t.size() > 0) chk("t1_when", q_t[0] - t0, 2);
        chk("t1_cnt2_end", 32'(dut.r_cnt[2]), 0);
        chk("t1_pend_end", 32'(bus.pend_any), 0);

        // All four at once, then one more on requester 0
        do_reset();
        bus.enable = 1'b1;
        tick();
        q_t.delete();
        q_id.delete();
        t0 = cyc;
        bus.req_pulse = 4'b1111;
        tick();
        bus.req_pulse = '0;
        tick_n(34);
        bus.req_pulse = 4'b0001;
        tick();
        bus.req_pulse = '0;
        tick_n(30);
        chk("t2_npulse", q_t.size(), 5);
        for (int i = 0; i < 5 && i < q_t.size(); i++) begin
            chk($sformatf("t2_id%0d", i), q_id[i], i % 4);
            chk($sformatf("t2_time%0d", i), q_t[i] - t0, 2 + 10 * i);
        end

        // Saturation with enable low
        do_reset();
        bus.req_pulse = 4'b0010;
        tick_n(17);
        bus.req_pulse = '0;
        chk("t3_cnt_sat", 32'(dut.r_cnt[1]), 15);
        chk("t3_ovf", 32'(bus.ovf), 32'h2);
        chk("t3_pend", 32'(bus.pend_any), 1);
        bus.req_pulse = 4'b0010;
        bus.clr_ovf = 1'b1;
        tick();
        bus.req_pulse = '0;
        bus.clr_ovf = 1'b0;
        chk("t3_ovf_set_wins", 32'(bus.ovf), 32'h2);
        chk("t3_cnt_held", 32'(dut.r_cnt[1]), 15);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        chk("t3_ovf_clr", 32'(bus.ovf), 0);
        chk("t3_no_pulse_disabled", q_t.size(), 0);
        bus.enable = 1'b1;
        tick_n(170);
        chk("t3_npulse", q_t.size(), 15);
        nother = 0;
        foreach (q_id[i]) if (q_id[i] != 1) nother++;
        chk("t3_ids", nother, 0);
        chk("t3_cnt_end", 32'(dut.r_cnt[1]), 0);
        chk("t3_busy_end", 32'(bus.busy), 0);

        // Request on requester 3 during its own LAUNCH
        do_reset();
        bus.enable = 1'b1;
        tick();
        q_t.delete();
        q_id.delete();
        t0 = cyc;
        bus.req_pulse = 4'b1000;
        tick();
        bus.req_pulse = '0;
        tick();
        chk("t4_pulse", 32'(bus.sync_pulse), 1);
        chk("t4_id", 32'(bus.sync_id), 3);
        bus.req_pulse = 4'b1000;
        tick();
        bus.req_pulse = '0;
        chk("t4_cnt_kept", 32'(dut.r_cnt[3]), 1);
        tick_n(27);
        chk("t4_npulse", q_t.size(), 2);
        if (q_t.size() > 1) begin
            chk("t4_spacing", q_t[1] - q_t[0], 10);
            chk("t4_id2", q_id[1], 3);
        end
        chk("t4_cnt_end", 32'(dut.r_cnt[3]), 0);

        // Enable dropped during HOLD
        do_reset();
        bus.enable = 1'b1;
        tick();
        q_t.delete();
        q_id.delete();
        t0 = cyc;
        bus.req_pulse = 4'b0011;
        tick();
        bus.req_pulse = '0;
        tick_n(4);
        chk("t5_in_hold", 32'(bus.busy), 1);
        bus.enable = 1'b0;
        tick_n(25);
        chk("t5_npulse", q_t.size(), 1);
        chk("t5_busy", 32'(bus.busy), 0);
        chk("t5_cnt1", 32'(dut.r_cnt[1]), 1);
        chk("t5_cnt0", 32'(dut.r_cnt[0]), 0);
        t1 = cyc;
        bus.enable = 1'b1;
        tick();
        chk("t5_relaunch", 32'(bus.sync_pulse), 1);
        chk("t5_relaunch_id", 32'(bus.sync_id), 1);
        tick_n(12);
        chk("t5_npulse2", q_t.size(), 2);
        if (q_t.size() > 1) chk("t5_relaunch_time", q_t[1] - t1, 1);

        // Reset in HOLD cycle 3 with counts [2,0,1,0]
        do_reset();
        bus.req_pulse = 4'b0101;
        tick();
        bus.req_pulse = 4'b0001;
        tick_n(2);
        bus.req_pulse = '0;
        bus.enable = 1'b1;
        tick();
        chk("t6_launch", 32'(bus.sync_pulse), 1);
        chk("t6_launch_id", 32'(bus.sync_id), 0);
        tick_n(3);
        chk("t6_cnt0", 32'(dut.r_cnt[0]), 2);
        chk("t6_cnt2", 32'(dut.r_cnt[2]), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_pulse", 32'(bus.sync_pulse), 0);
        chk("t6_id", 32'(bus.sync_id), 0);
        chk("t6_busy", 32'(bus.busy), 0);
        chk("t6_ovf", 32'(bus.ovf), 0);
        chk("t6_pend", 32'(bus.pend_any), 0);
        chk("t6_cnt", 32'(dut.r_cnt), 0);
        q_t.delete();
        q_id.delete();
        tick_n(20);
        chk("t6_quiet", q_t.size(), 0);
        bus.req_pulse = 4'b0101;
        tick();
        bus.req_pulse = '0;
        tick();
        chk("t6_new_pulse", 32'(bus.sync_pulse), 1);
        chk("t6_new_id", 32'(bus.sync_id), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
